seq_signed_divider16: RTL and testbench
=======================================

// Module: seq_signed_divider16
// PURPOSE
//  Multi-cycle signed two's-complement divider for the ALU. Shares operand/result conventions with the 16-bit add/sub unit.
//  Computes quotient and remainder of A/B by restoring shift-subtract, one bit per clock.
//  Result is truncating: quotient rounds toward zero, remainder takes the sign of the dividend.
//  Sits beside the adder in the ALU datapath. Uses a start/busy/done handshake because it takes multiple cycles.
// PARAMETERS
//  WIDTH    16   operand/result width in bits (two's complement); must be >= 4
//  SIGNED   1    1 = signed operands; 0 = unsigned (sign fixups and ovf disabled)
// PORTS
//  clk      in   1      rising-edge clock
//  rst      in   1      synchronous, active-high reset
//  start    in   1      request; sampled only in IDLE
//  A        in   WIDTH  dividend; captured on the accepted start edge
//  B        in   WIDTH  divisor; captured on the accepted start edge
//  busy     out  1      1 from the accepted start until done drops
//  done     out  1      single-cycle pulse; Q/R/flags valid in that cycle
//  Q        out  WIDTH  quotient; held until the next accepted start
//  R        out  WIDTH  remainder; held until the next accepted start
//  dz       out  1      divide-by-zero flag; valid with done
//  ovf      out  1      signed overflow flag (-2^(W-1) / -1); valid with done
// BEHAVIOUR
//  Clock and reset: one clock. Reset is synchronous and active-high.
//  Reset: state=IDLE. busy, done, dz, ovf = 0. Q, R = 0. Internal registers cleared.
//  Reset mid-operation aborts the division: no done pulse, and Q/R/flags return to 0.
//  FSM states: IDLE, DIVIDE, FIXUP, DONE.
//  IDLE: start=1 and B!=0 -> DIVIDE.
//    Capture |A| and |B| (or raw values if SIGNED=0), sign_q = A[W-1]^B[W-1], sign_r = A[W-1].
//    Clear the partial remainder (W+1 bits) and the step counter.
//  IDLE: start=1 and B==0 -> DONE.
//    Sets Q = all ones, R = A, dz = 1, ovf = 0.
//  DIVIDE: runs exactly WIDTH cycles, MSB first.
//    Each cycle, shift {rem, dvd} left by 1 and compute trial = rem - |B| at W+1 bits.
//    If trial >= 0: rem = trial, quotient bit = 1. Otherwise keep rem, quotient bit = 0.
//    Leave DIVIDE when counter == WIDTH-1.
//  FIXUP: 1 cycle.
//    Q = sign_q ? -q : q. R = sign_r ? -rem : rem.
//    ovf = SIGNED & (A == 100..0) & (B == all ones). On ovf, Q = 100..0 and R = 0.
//  DONE: 1 cycle with done=1, busy=1, then -> IDLE. busy drops with done.
//  Latency: start accepted at edge t0 gives done=1 in cycle t0+WIDTH+2 (18 for W=16).
//    Divide-by-zero gives done at t0+1.
//  start while busy is ignored: no queueing, and A/B are not re-sampled.
//    start in the DONE cycle is also ignored. It is accepted from the next IDLE cycle.
//  Flags dz and ovf clear on the next accepted start. Between operations Q/R/dz/ovf hold.
//  |-2^(W-1)| is handled as an unsigned W-bit magnitude. Internal magnitude paths are W bits unsigned.
//  Rem/trial path is W+1 bits so the subtract borrow is never lost.
// STRUCTURE
//  Package div_pkg holds:
//    state encoding localparams S_IDLE=2'd0, S_DIVIDE=2'd1, S_FIXUP=2'd2, S_DONE=2'd3;
//    the counter-width function clog2.
//  Sub-module div_step: combinational W+1-bit trial subtract.
//    Inputs rem, dvd_msb, divisor. Outputs next_rem and qbit.
//    It is the only arithmetic in the loop. The top level holds the FSM, registers and sign fixup.
// TESTING (WIDTH=16, SIGNED=1)
//  A=100,B=7 -> done at cycle 18, Q=0x000E (14), R=0x0002, dz=0, ovf=0.
//  A=-100 (0xFF9C),B=7 -> Q=0xFFF2 (-14), R=0xFFFE (-2). A=100,B=-7 -> Q=0xFFF2, R=0x0002.
//  A=0x0010,B=0 -> done 1 cycle after start, dz=1, Q=0xFFFF, R=0x0010.
//    The next start with A=16,B=4 gives Q=4, R=0, dz=0.
//  A=0x8000,B=0xFFFF -> ovf=1, Q=0x8000, R=0. A=0x8000,B=1 -> Q=0x8000, ovf=0.
//  start pulsed again at cycles 5 and 18 with other operands -> ignored; first result is unchanged.
//    A start in the cycle after done is accepted.
//  rst=1 at cycle 9 of a division -> next cycle busy=0, Q=R=0, no done pulse.
//    A new start then completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// the width helper used to size the step counter.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FIXUP  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Number of bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and keeps the trial difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem[WIDTH-1:0], dvd_msb};
  assign trial   = shifted - {1'b0, divisor};

  // A set top bit in rem means the shifted value already exceeds any divisor,
  // so the step must succeed regardless of the truncated trial sign.
  assign qbit     = rem[WIDTH] | ~trial[WIDTH];
  assign next_rem = qbit ? trial : shifted;

endmodule

// File: rtl/seq_signed_divider16.sv
// Multi-cycle truncating divider (quotient toward zero, remainder follows the
// dividend) with a start/busy/done handshake; one quotient bit per clock.
module seq_signed_divider16
  import div_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dz,
  output logic             ovf
);

  localparam int CW = clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic [WIDTH:0]   rem_reg, rem_next;
  logic [WIDTH-1:0] div_reg, div_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             sign_q_reg, sign_q_next;
  logic             sign_r_reg, sign_r_next;
  logic             ovf_cand_reg, ovf_cand_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic             dz_reg, dz_next;
  logic             ovf_reg, ovf_next;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   step_rem;
  logic             step_qbit;

  // The most negative value negates to itself, which is exactly its
  // unsigned magnitude, so no special case is needed here.
  assign a_mag = (SIGNED && A[WIDTH-1]) ? -A : A;
  assign b_mag = (SIGNED && B[WIDTH-1]) ? -B : B;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_reg),
    .dvd_msb (dvd_reg[WIDTH-1]),
    .divisor (div_reg),
    .next_rem(step_rem),
    .qbit    (step_qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      dvd_reg      <= '0;
      rem_reg      <= '0;
      div_reg      <= '0;
      cnt_reg      <= '0;
      sign_q_reg   <= 1'b0;
      sign_r_reg   <= 1'b0;
      ovf_cand_reg <= 1'b0;
      q_reg        <= '0;
      r_reg        <= '0;
      dz_reg       <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dvd_reg      <= dvd_next;
      rem_reg      <= rem_next;
      div_reg      <= div_next;
      cnt_reg      <= cnt_next;
      sign_q_reg   <= sign_q_next;
      sign_r_reg   <= sign_r_next;
      ovf_cand_reg <= ovf_cand_next;
      q_reg        <= q_next;
      r_reg        <= r_next;
      dz_reg       <= dz_next;
      ovf_reg      <= ovf_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    dvd_next      = dvd_reg;
    rem_next      = rem_reg;
    div_next      = div_reg;
    cnt_next      = cnt_reg;
    sign_q_next   = sign_q_reg;
    sign_r_next   = sign_r_reg;
    ovf_cand_next = ovf_cand_reg;
    q_next        = q_reg;
    r_next        = r_reg;
    dz_next       = dz_reg;
    ovf_next      = ovf_reg;
    busy          = (state_reg != S_IDLE);
    done          = (state_reg == S_DONE);

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          dz_next  = 1'b0;
          ovf_next = 1'b0;
          if (B == '0) begin
            // Divide-by-zero skips the loop and reports straight away.
            q_next     = '1;
            r_next     = A;
            dz_next    = 1'b1;
            state_next = S_DONE;
          end else begin
            dvd_next      = a_mag;
            div_next      = b_mag;
            rem_next      = '0;
            cnt_next      = '0;
            sign_q_next   = SIGNED && (A[WIDTH-1] ^ B[WIDTH-1]);
            sign_r_next   = SIGNED && A[WIDTH-1];
            ovf_cand_next = SIGNED && (A == MIN_NEG) && (B == '1);
            state_next    = S_DIVIDE;
          end
        end
      end

      S_DIVIDE: begin
        // Quotient bits shift in at the bottom as dividend bits leave the top.
        rem_next = step_rem;
        dvd_next = {dvd_reg[WIDTH-2:0], step_qbit};
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST_STEP) begin
          state_next = S_FIXUP;
        end
      end

      S_FIXUP: begin
        if (ovf_cand_reg) begin
          q_next   = MIN_NEG;
          r_next   = '0;
          ovf_next = 1'b1;
        end else begin
          q_next = sign_q_reg ? -dvd_reg : dvd_reg;
          r_next = sign_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
        end
        state_next = S_DONE;
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign Q   = q_reg;
  assign R   = r_reg;
  assign dz  = dz_reg;
  assign ovf = ovf_reg;

endmodule

// File: tb/tb_seq_signed_divider16.sv
// Bench for seq_signed_divider16: directed vector table, random vectors
// against a reference model, and hand-built handshake/reset sequences.
module tb_seq_signed_divider16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Q;
  logic [15:0] R;
  logic        dz;
  logic        ovf;

  seq_signed_divider16 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .Q    (Q),
    .R    (R),
    .dz   (dz),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[13];
  int   checks = 0;
  int   passed = 0;
  int   cycle_cnt = 0;
  int   op_id = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Scoreboard: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) chk("done_single_pulse", {31'd0, done}, 32'd0);
    prev_done = done;
    if (done && !rst) begin
      if (sb.size() == 0) begin
        checks = checks + 1;
        $display("FAIL unexpected_done: done=1 with no operation pending at cycle %0d", cycle_cnt);
      end else begin
        e = sb.pop_front();
        chk($sformatf("op%0d_Q", op_id), {16'd0, Q}, {16'd0, e.q});
        chk($sformatf("op%0d_R", op_id), {16'd0, R}, {16'd0, e.r});
        chk($sformatf("op%0d_dz", op_id), {31'd0, dz}, {31'd0, e.dz});
        chk($sformatf("op%0d_ovf", op_id), {31'd0, ovf}, {31'd0, e.ovf});
        chk($sformatf("op%0d_latency", op_id), cycle_cnt - e.acc, e.lat);
        chk($sformatf("op%0d_busy_with_done", op_id), {31'd0, busy}, 32'd1);
        $display("op%0d: Q=%h R=%h dz=%b ovf=%b latency=%0d", op_id, Q, R, dz, ovf, cycle_cnt - e.acc);
        op_id = op_id + 1;
      end
    end
  end

  task automatic push_exp(input logic [15:0] q, input logic [15:0] r, input logic d,
                          input logic o, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dz = d; e.ovf = o; e.lat = lat; e.acc = cycle_cnt;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    chk("drain_within_budget", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] q,
                       input logic [15:0] r, input logic d, input logic o, input int lat);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    push_exp(q, r, d, o, lat);
    @(negedge clk);
    start = 1'b0;
    wait_drain();
  endtask

  // Independent reference: SV integer division truncates toward zero.
  task automatic model(input logic [15:0] a, input logic [15:0] b, output logic [15:0] q,
                       output logic [15:0] r, output logic d, output logic o, output int lat);
    int sa, sbv, qi, ri;
    sa = int'($signed(a)); sbv = int'($signed(b));
    d = 1'b0; o = 1'b0; lat = 18;
    if (b == 16'h0000) begin
      q = 16'hFFFF; r = a; d = 1'b1; lat = 1;
    end else if (a == 16'h8000 && b == 16'hFFFF) begin
      q = 16'h8000; r = 16'h0000; o = 1'b1;
    end else begin
      qi = sa / sbv; ri = sa % sbv;
      q = qi[15:0]; r = ri[15:0];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    logic [15:0] ra, rb, mq, mr;
    logic md, mo;
    int ml;

    vecs[0]  = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 18};
    vecs[1]  = '{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18};
    vecs[2]  = '{16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 18};
    vecs[3]  = '{16'h0010, 16'h0000, 16'hFFFF, 16'h0010, 1'b1, 1'b0, 1};
    vecs[4]  = '{16'h0010, 16'h0004, 16'h0004, 16'h0000, 1'b0, 1'b0, 18};
    vecs[5]  = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, 18};
    vecs[6]  = '{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 18};
    vecs[7]  = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 18};
    vecs[8]  = '{16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 18};
    vecs[9]  = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 18};
    vecs[10] = '{16'h0003, 16'h0010, 16'h0000, 16'h0003, 1'b0, 1'b0, 18};
    vecs[11] = '{16'h8000, 16'h0007, 16'hEDB7, 16'hFFFF, 1'b0, 1'b0, 18};
    vecs[12] = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 18};

    rst = 1'b1; start = 1'b0; A = 16'h0000; B = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_Q", {16'd0, Q}, 32'd0);
    chk("reset_R", {16'd0, R}, 32'd0);
    chk("reset_dz", {31'd0, dz}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ovf, vecs[i].lat);

    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = (i % 7 == 3) ? 16'h0000 : 16'($urandom_range(0, 65535));
      model(ra, rb, mq, mr, md, mo, ml);
      do_op(ra, rb, mq, mr, md, mo, ml);
    end

    // Starts at cycles 5 (DIVIDE) and 18 (DONE) are ignored; cycle 19 is accepted.
    @(negedge clk);
    A = 16'h0064; B = 16'h0007; start = 1'b1;
    push_exp(16'h000E, 16'h0002, 1'b0, 1'b0, 18);
    c = cycle_cnt;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) chk("busy_after_accept", {31'd0, busy}, 32'd1);
      if (n == 5 || n == 18) begin
        A = 16'h1234; B = 16'h0003; start = 1'b1;
      end
      if (n == 19) begin
        chk("cycle_alignment", cycle_cnt - c, 19);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        A = 16'h0010; B = 16'h0004; start = 1'b1;
        push_exp(16'h0004, 16'h0000, 1'b0, 1'b0, 18);
      end
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    chk("Q_held_idle", {16'd0, Q}, 32'h0004);

    // Reset in cycle 9 of a division aborts it.
    do_op(16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 18);
    @(negedge clk);
    A = 16'h0064; B = 16'h0007; start = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_Q", {16'd0, Q}, 32'd0);
    chk("abort_R", {16'd0, R}, 32'd0);
    repeat (25) @(negedge clk);
    do_op(16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 18);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
